// File: rtl/conv_batch_ctrl.sv
// conv_batch_ctrl: runs the Sobel core over a batch of frames and relocates its BRAM addresses per frame
module conv_batch_ctrl #(
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int FRAME_BYTES = IMG_WIDTH * IMG_HEIGHT * 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic        cmd_abort,
    input  logic [7:0]  cfg_frames,
    input  logic [31:0] cfg_src_base,
    input  logic [31:0] cfg_dst_base,
    input  logic        irq_clr,
    output logic        busy,
    output logic        irq,
    output logic        cmd_err,
    output logic        aborted,
    output logic [7:0]  frames_done,
    output logic [31:0] cycle_cnt,
    output logic        conv_start,
    input  logic        conv_done,
    input  logic [31:0] conv_b0_addr,
    input  logic        conv_b0_en,
    input  logic [31:0] conv_b1_addr,
    input  logic [31:0] conv_b1_din,
    input  logic        conv_b1_we,
    output logic [31:0] bram0_addr,
    output logic        bram0_en,
    output logic [31:0] bram1_addr,
    output logic [31:0] bram1_din,
    output logic        bram1_we
);
    localparam logic [31:0] STRIDE = 32'(FRAME_BYTES);

    typedef enum logic [2:0] {IDLE, LAUNCH, RELEASE, NEXT, FINISH} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        frame_end;
    logic        fin;
    logic        abort_q;
    logic        abort_pend;
    logic [7:0]  frames_left;
    logic [31:0] src_cur;
    logic [31:0] dst_cur;

    assign fin        = state == FINISH;
    assign conv_start = state == LAUNCH;
    assign abort_q    = abort_pend | (cmd_abort & busy);
    assign bram0_addr = conv_b0_addr + src_cur;
    assign bram1_addr = conv_b1_addr + dst_cur;
    assign bram0_en   = conv_b0_en;
    assign bram1_din  = conv_b1_din;
    assign bram1_we   = conv_b1_we;

    // state register; reset drops conv_start at once since it decodes LAUNCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state: accept a command, then one start/done handshake per frame
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: if (cmd_start && cfg_frames != 8'd0) begin
                accept    = 1'b1;
                state_nxt = LAUNCH;
            end
            LAUNCH: if (conv_done) state_nxt = RELEASE;
            RELEASE: if (!conv_done) begin
                frame_end = 1'b1;
                state_nxt = (frames_left != 8'd1 && !abort_q) ? NEXT : FINISH;
            end
            NEXT:    state_nxt = LAUNCH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // batch bookkeeping, base relocation and host status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            irq         <= 1'b0;
            cmd_err     <= 1'b0;
            aborted     <= 1'b0;
            frames_done <= 8'd0;
            cycle_cnt   <= 32'd0;
            abort_pend  <= 1'b0;
            frames_left <= 8'd0;
            src_cur     <= 32'd0;
            dst_cur     <= 32'd0;
        end else begin
            cmd_err <= cmd_start & ~accept;
            irq     <= fin | (irq & ~irq_clr);
            if (accept) begin
                src_cur     <= cfg_src_base;
                dst_cur     <= cfg_dst_base;
                frames_left <= cfg_frames;
                frames_done <= 8'd0;
                cycle_cnt   <= 32'd1;
                aborted     <= 1'b0;
                abort_pend  <= 1'b0;
                busy        <= 1'b1;
            end else begin
                if (state != IDLE && !(&cycle_cnt)) cycle_cnt <= cycle_cnt + 32'd1;
                if (cmd_abort && busy) abort_pend <= 1'b1;
                if (frame_end) begin
                    frames_done <= frames_done + 8'd1;
                    frames_left <= frames_left - 8'd1;
                end
                if (state == NEXT) begin
                    src_cur <= src_cur + STRIDE;
                    dst_cur <= dst_cur + STRIDE;
                end
                if (fin) begin
                    busy       <= 1'b0;
                    aborted    <= abort_q;
                    abort_pend <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_batch_ctrl.sv
// tb_conv_batch_ctrl: randomized core/host stimulus checked every cycle against a batch-level model
module tb_conv_batch_ctrl;
    localparam logic [31:0] FB = 32'd4096;
    localparam int P_IDLE = 0, P_RUN = 1, P_REL = 2, P_GAP = 3, P_END = 4;

    logic        clk = 0, rst = 0;
    logic        cmd_start = 0, cmd_abort = 0, irq_clr = 0;
    logic [7:0]  cfg_frames = 0;
    logic [31:0] cfg_src_base = 0, cfg_dst_base = 0;
    logic        busy, irq, cmd_err, aborted, conv_start;
    logic [7:0]  frames_done;
    logic [31:0] cycle_cnt;
    logic        conv_done = 0;
    logic [31:0] conv_b0_addr = 0, conv_b1_addr = 0, conv_b1_din = 0;
    logic        conv_b0_en = 0, conv_b1_we = 0;
    logic [31:0] bram0_addr, bram1_addr, bram1_din;
    logic        bram0_en, bram1_we;

    int errors = 0, checks = 0;
    bit fix_addr = 0;
    int rises = 0;
    logic prev_cs = 0;
    logic [31:0] rise_src[$];

    // behavioural model state
    int          m_phase = P_IDLE;
    int          m_left = 0;
    logic        m_busy = 0, m_irq = 0, m_err = 0, m_ab = 0, m_pend = 0, ab_now;
    logic [7:0]  m_fd = 0;
    logic [31:0] m_cnt = 0, m_src = 0, m_dst = 0;

    conv_batch_ctrl dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_frames(cfg_frames), .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
        .irq_clr(irq_clr), .busy(busy), .irq(irq), .cmd_err(cmd_err), .aborted(aborted),
        .frames_done(frames_done), .cycle_cnt(cycle_cnt), .conv_start(conv_start),
        .conv_done(conv_done), .conv_b0_addr(conv_b0_addr), .conv_b0_en(conv_b0_en),
        .conv_b1_addr(conv_b1_addr), .conv_b1_din(conv_b1_din), .conv_b1_we(conv_b1_we),
        .bram0_addr(bram0_addr), .bram0_en(bram0_en), .bram1_addr(bram1_addr),
        .bram1_din(bram1_din), .bram1_we(bram1_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: a batch is a sequence of frames, each "core runs" then "core releases", then a gap or the end
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase = P_IDLE; m_busy = 0; m_irq = 0; m_err = 0; m_ab = 0; m_pend = 0;
            m_fd = 0; m_cnt = 0; m_src = 0; m_dst = 0; m_left = 0;
        end else begin
            ab_now = m_pend || (cmd_abort && m_busy);
            m_err  = cmd_start && !(m_phase == P_IDLE && cfg_frames != 0);
            m_irq  = (m_phase == P_END) || (m_irq && !irq_clr);
            if (m_phase == P_IDLE) begin
                if (cmd_start && cfg_frames != 0) begin
                    m_src = cfg_src_base; m_dst = cfg_dst_base; m_left = int'(cfg_frames);
                    m_fd = 0; m_cnt = 1; m_ab = 0; m_pend = 0; m_busy = 1; m_phase = P_RUN;
                end
            end else begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (cmd_abort && m_busy) m_pend = 1;
                if (m_phase == P_RUN) begin
                    if (conv_done) m_phase = P_REL;
                end else if (m_phase == P_REL) begin
                    if (!conv_done) begin
                        m_fd = m_fd + 1;
                        m_left = m_left - 1;
                        m_phase = (m_left != 0 && !ab_now) ? P_GAP : P_END;
                    end
                end else if (m_phase == P_GAP) begin
                    m_src = m_src + FB; m_dst = m_dst + FB; m_phase = P_RUN;
                end else begin
                    m_busy = 0; m_ab = ab_now; m_pend = 0; m_phase = P_IDLE;
                end
            end
        end
    end

    // per-cycle compare, then the core model reacts to conv_start with random latency
    initial begin
        int lat = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                conv_done = 0; lat = 0; prev_cs = 0;
            end else begin
                check("busy", {31'd0, busy}, {31'd0, m_busy});
                check("irq", {31'd0, irq}, {31'd0, m_irq});
                check("cmd_err", {31'd0, cmd_err}, {31'd0, m_err});
                check("aborted", {31'd0, aborted}, {31'd0, m_ab});
                check("frames_done", {24'd0, frames_done}, {24'd0, m_fd});
                check("cycle_cnt", cycle_cnt, m_cnt);
                check("conv_start", {31'd0, conv_start}, {31'd0, m_phase == P_RUN});
                check("bram0_addr", bram0_addr, conv_b0_addr + m_src);
                check("bram1_addr", bram1_addr, conv_b1_addr + m_dst);
                check("passthru", {bram1_din[29:0], bram0_en, bram1_we},
                      {conv_b1_din[29:0], conv_b0_en, conv_b1_we});
                if (conv_start && !prev_cs) begin
                    rises++;
                    rise_src.push_back(bram0_addr - conv_b0_addr);
                end
                prev_cs = conv_start;
                if (conv_start != conv_done) begin
                    if (lat == 0) begin
                        conv_done = conv_start;
                        lat = int'($urandom_range(0, 3));
                    end else lat--;
                end
                if (!fix_addr) begin
                    conv_b0_addr = $urandom; conv_b1_addr = $urandom;
                end
                conv_b1_din = $urandom;
                conv_b0_en = 1'($urandom_range(0, 1));
                conv_b1_we = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic start_batch(input logic [7:0] n, input logic [31:0] s, input logic [31:0] d);
        @(negedge clk);
        cfg_frames = n; cfg_src_base = s; cfg_dst_base = d; cmd_start = 1;
        @(negedge clk);
        cmd_start = 0;
    endtask

    task automatic wait_idle(input bit rnd);
        int n = 0;
        while (m_phase != P_IDLE && n < 3000) begin
            @(negedge clk);
            cmd_abort = rnd && ($urandom_range(0, 15) == 0);
            cmd_start = rnd && ($urandom_range(0, 24) == 0);
            if (rnd) begin
                irq_clr = ($urandom_range(0, 3) == 0);
                cfg_frames = 8'($urandom_range(0, 5));
            end
            n++;
        end
        cmd_abort = 0; cmd_start = 0;
        check("idle_timeout", {31'd0, m_phase == P_IDLE}, 32'd1);
    endtask

    initial begin
        int n;
        logic [31:0] v;
        #1 rst = 1;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cnt", cycle_cnt, 32'd0);
        check("rst_start", {31'd0, conv_start}, 32'd0);
        @(negedge clk); @(negedge clk);
        #2 rst = 0;

        // single frame relocation
        fix_addr = 1; conv_b0_addr = 32'h10; conv_b1_addr = 32'h10;
        start_batch(8'd1, 32'h1000, 32'h8000);
        check("t1_b0", bram0_addr, 32'h1010);
        check("t1_b1", bram1_addr, 32'h8010);
        wait_idle(0);
        check("t1_irq", {31'd0, irq}, 32'd1);
        check("t1_fd", {24'd0, frames_done}, 32'd1);

        // three frames step the source base by one frame
        conv_b0_addr = 0;
        rise_src.delete(); rises = 0;
        start_batch(8'd3, 32'h0, 32'h4000);
        wait_idle(0);
        check("t2_rises", rises, 32'd3);
        for (int i = 0; i < 3; i++) begin
            v = (i < rise_src.size()) ? rise_src[i] : 32'hDEAD_BEEF;
            check("t2_src", v, FB * 32'(i));
        end
        fix_addr = 0;

        // abort during frame 2 of 4
        rises = 0;
        start_batch(8'd4, 32'h100, 32'h200);
        n = 0;
        while (rises < 2 && n < 500) begin @(negedge clk); n++; end
        cmd_abort = 1;
        @(negedge clk);
        cmd_abort = 0;
        wait_idle(0);
        check("t3_fd", {24'd0, frames_done}, 32'd2);
        check("t3_ab", {31'd0, aborted}, 32'd1);
        check("t3_irq", {31'd0, irq}, 32'd1);
        check("t3_rises", rises, 32'd2);

        // zero frames rejected, then a start during a batch rejected
        rises = 0;
        start_batch(8'd0, 32'h0, 32'h0);
        check("t4_err", {31'd0, cmd_err}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        check("t4_norise", rises, 32'd0);
        start_batch(8'd2, 32'h0, 32'h0);
        @(negedge clk);
        cfg_frames = 8'd3; cmd_start = 1;
        @(negedge clk);
        cmd_start = 0;
        check("t4_err2", {31'd0, cmd_err}, 32'd1);
        check("t4_busy2", {31'd0, busy}, 32'd1);
        wait_idle(0);
        check("t4_fd", {24'd0, frames_done}, 32'd2);

        // irq_clr coinciding with the end of the batch loses to the set
        irq_clr = 1;
        start_batch(8'd1, 32'h0, 32'h0);
        wait_idle(0);
        check("t6_irq_set", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("t6_irq_clr", {31'd0, irq}, 32'd0);
        irq_clr = 0;

        // asynchronous reset while the core is started
        start_batch(8'd3, 32'h0, 32'h0);
        #2 rst = 1;
        #1;
        check("t5_start", {31'd0, conv_start}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_fd", {24'd0, frames_done}, 32'd0);
        check("t5_cnt", cycle_cnt, 32'd0);
        @(negedge clk);
        #2 rst = 0;
        start_batch(8'd2, 32'h40, 32'h80);
        wait_idle(0);
        check("t5_after", {24'd0, frames_done}, 32'd2);
        check("t5_irq", {31'd0, irq}, 32'd1);

        // randomized batches with stray commands, aborts and irq clears
        for (int b = 0; b < 25; b++) begin
            start_batch(8'($urandom_range(0, 5)), $urandom, $urandom);
            wait_idle(1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            irq_clr = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
